icache_ctrl: RTL and testbench

//  Direct-mapped instruction cache between the IF stage and the instruction ROM.
//  It answers IF fetch requests with a same-cycle hit indication. On a miss it

---
 rtl/icache_ctrl_pkg.sv | 10 +
 rtl/icache_array.sv | 39 +++
 rtl/icache_ctrl.sv | 118 +++++++++++
 tb/tb_icache_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the instruction cache: datapath width and FSM state encodings.
package icache_ctrl_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESP   = 2'd2
  } icache_state_e;
endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid bits with async clear, tag/data arrays without reset.
// Combinational read port plus one synchronous whole-line write port.
module icache_array #(
  parameter int SETS    = 64,
  parameter int TAG_W   = 22,
  parameter int LINE_W  = 128,
  parameter int INDEX_W = $clog2(SETS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line
);
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else if (wr_en) valid_q[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];
endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped I-cache controller: zero-latency hits, single-line ROM refill on miss,
// one-cycle response after refill unless a redirect arrived while the miss was in flight.
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       if_req_Icache_i,
  input  logic                       if_jump_Icache_i,
  input  logic [31:0]                if_addr_i,
  output logic                       Icache_hit_o,
  output logic                       Icache_ready_o,
  output logic [31:0]                Icache_inst_o,
  output logic                       Icache_req_rom_o,
  output logic [31:0]                Icache_addr_rom_o,
  input  logic                       rom_ready_i,
  input  logic [32*LINE_WORDS-1:0]   rom_data_i
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int TAG_W   = XLEN - INDEX_W - OFF_W - 2;
  localparam int LINE_W  = XLEN * LINE_WORDS;

  icache_state_e state_q;
  logic [XLEN-1:0] miss_addr_q;
  logic            req_rom_q;
  logic            jmp_pend_q;
  logic [XLEN-1:0] resp_inst_q;

  logic [OFF_W-1:0]   if_off, miss_off;
  logic [INDEX_W-1:0] if_idx, miss_idx;
  logic [TAG_W-1:0]   if_tag, miss_tag;

  assign if_off   = if_addr_i[OFF_W+1:2];
  assign if_idx   = if_addr_i[OFF_W+2 +: INDEX_W];
  assign if_tag   = if_addr_i[XLEN-1 -: TAG_W];
  assign miss_off = miss_addr_q[OFF_W+1:2];
  assign miss_idx = miss_addr_q[OFF_W+2 +: INDEX_W];
  assign miss_tag = miss_addr_q[XLEN-1 -: TAG_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[1:0], miss_addr_q[1:0]};

  logic                                rd_valid;
  logic [TAG_W-1:0]                    rd_tag;
  logic [LINE_WORDS-1:0][XLEN-1:0]     rd_words;
  logic [LINE_WORDS-1:0][XLEN-1:0]     rom_words;
  logic                                line_we;

  assign rom_words = rom_data_i;
  assign line_we   = (state_q == ST_REFILL) && rom_ready_i;

  icache_array #(
    .SETS   (SETS),
    .TAG_W  (TAG_W),
    .LINE_W (LINE_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (if_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_words),
    .wr_en    (line_we),
    .wr_idx   (miss_idx),
    .wr_tag   (miss_tag),
    .wr_line  (rom_data_i)
  );

  logic hit, resp_ok;
  assign hit = (state_q == ST_IDLE) && if_req_Icache_i && rd_valid && (rd_tag == if_tag);
  // A redirect seen in the response cycle itself also makes the refilled word stale.
  assign resp_ok = (state_q == ST_RESP) && !jmp_pend_q && !if_jump_Icache_i;

  assign Icache_hit_o      = hit;
  assign Icache_ready_o    = hit || resp_ok;
  assign Icache_inst_o     = hit ? rd_words[if_off] : (resp_ok ? resp_inst_q : '0);
  assign Icache_req_rom_o  = req_rom_q;
  assign Icache_addr_rom_o = {miss_addr_q[XLEN-1:OFF_W+2], {(OFF_W+2){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      miss_addr_q <= '0;
      req_rom_q   <= 1'b0;
      jmp_pend_q  <= 1'b0;
      resp_inst_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          jmp_pend_q <= 1'b0;
          if (if_req_Icache_i && !hit) begin
            miss_addr_q <= if_addr_i;
            req_rom_q   <= 1'b1;
            state_q     <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (if_jump_Icache_i) jmp_pend_q <= 1'b1;
          // The refill always completes; dropping req is what releases ROM ready.
          if (rom_ready_i) begin
            resp_inst_q <= rom_words[miss_off];
            req_rom_q   <= 1'b0;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          jmp_pend_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed plus randomized fetch sequences against a set/tag occupancy model and a ROM responder.
module tb_icache_ctrl;
  localparam int SETS = 64;
  localparam int LW   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, if_jump;
  logic [31:0]       if_addr;
  logic              hit, rdy, req_rom;
  logic [31:0]       inst, addr_rom;
  logic              rom_ready;
  logic [32*LW-1:0]  rom_data;

  int errors = 0;
  int checks = 0;
  int rom_lat = 5;
  int rom_cnt = 0;
  int edges = 0;
  int pulses = 0;

  logic        mv [SETS];
  logic [31:0] mt [SETS];

  icache_ctrl #(.SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .if_req_Icache_i   (if_req),
    .if_jump_Icache_i  (if_jump),
    .if_addr_i         (if_addr),
    .Icache_hit_o      (hit),
    .Icache_ready_o    (rdy),
    .Icache_inst_o     (inst),
    .Icache_req_rom_o  (req_rom),
    .Icache_addr_rom_o (addr_rom),
    .rom_ready_i       (rom_ready),
    .rom_data_i        (rom_data)
  );

  always #5 clk = ~clk;

  // ROM image: word at byte address a; 0x40..0x4C hold 1..4.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a >> 2) - 32'd15;
  endfunction

  function automatic logic [32*LW-1:0] rom_line(input logic [31:0] a);
    logic [32*LW-1:0] l;
    for (int w = 0; w < LW; w++) l[w*32 +: 32] = rom_word(a + 32'(4*w));
    return l;
  endfunction

  // ROM responder: ready rom_lat cycles after req, held until req drops.
  always @(negedge clk) begin
    if (!req_rom) begin
      if (rom_ready) rom_data = {$urandom, $urandom, $urandom, $urandom};
      rom_ready = 1'b0;
      rom_cnt   = 0;
    end else if (!rom_ready) begin
      rom_cnt++;
      if (rom_cnt >= rom_lat) begin
        rom_ready = 1'b1;
        rom_data  = rom_line(addr_rom);
        edges++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) mv[s] = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input int jump_at, input int rst_at, output logic was_hit);
    int n;
    int idx;
    logic jumped;
    logic exp_hit;
    idx = int'((a / 16) % SETS);
    @(negedge clk);
    if_req = 1'b1; if_addr = a; if_jump = 1'b0;
    #1;
    exp_hit = mv[idx] && (mt[idx] == a / 1024);
    was_hit = hit;
    chk("hit", 32'(hit), 32'(exp_hit));
    chk("ready_req", 32'(rdy), 32'(exp_hit));
    if (exp_hit) begin
      chk("hit_inst", inst, rom_word(a));
      return;
    end
    n = 0; jumped = 1'b0;
    while (1) begin
      @(negedge clk);
      n++;
      if_jump = (n == jump_at);
      jumped  = jumped | if_jump;
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_req_rom", 32'(req_rom), 32'd0);
        chk("rst_ready", 32'(rdy), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1; if_req = 1'b0; if_jump = 1'b0;
        return;
      end
      #1;
      chk("req_rom", 32'(req_rom), 32'd1);
      chk("addr_rom", addr_rom, a - (a % (4*LW)));
      chk("ready_wait", 32'(rdy), 32'd0);
      chk("hit_wait", 32'(hit), 32'd0);
      if (rom_ready) break;
      if (n >= 40) begin
        chk("rom_timeout", 32'(n), 32'(rom_lat));
        if_jump = 1'b0;
        return;
      end
    end
    chk("latency", 32'(n), 32'(rom_lat));
    @(negedge clk);
    if_jump = 1'b0;
    #1;
    chk("req_rom_drop", 32'(req_rom), 32'd0);
    chk("resp_ready", 32'(rdy), 32'(!jumped));
    if (!jumped) begin
      chk("resp_inst", inst, rom_word(a));
      if (rdy) pulses++;
    end
    mv[idx] = 1'b1;
    mt[idx] = a / 1024;
  endtask

  initial begin
    logic h;
    int e0, p0;
    logic [31:0] a;
    rst_n = 1'b0; if_req = 1'b0; if_jump = 1'b0; if_addr = '0;
    rom_ready = 1'b0; rom_data = '0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_req_rom", 32'(req_rom), 32'd0);
    chk("rst_addr_rom", addr_rom, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // cold miss then hit on the same line
    fetch(32'h40, 0, 0, h);
    chk("t1_miss", 32'(h), 32'd0);
    fetch(32'h48, 0, 0, h);
    chk("t2_hit", 32'(h), 32'd1);
    chk("t2_inst", inst, 32'd3);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("noreq_hit", 32'(hit), 32'd0);
    chk("noreq_ready", 32'(rdy), 32'd0);

    // conflict on index 4
    fetch(32'h440, 0, 0, h);
    chk("t3_conflict_miss", 32'(h), 32'd0);
    fetch(32'h40, 0, 0, h);
    chk("t3_evicted_miss", 32'(h), 32'd0);

    // redirect two cycles into refill, and one coinciding with ROM ready
    fetch(32'h80, 2, 0, h);
    fetch(32'h80, 0, 0, h);
    chk("t4_rehit", 32'(h), 32'd1);
    rom_lat = 3;
    fetch(32'h300, 3, 0, h);
    fetch(32'h304, 0, 0, h);
    chk("jump_on_ready_rehit", 32'(h), 32'd1);

    // reset in the middle of a refill
    rom_lat = 20;
    fetch(32'hC0, 0, 3, h);
    rom_lat = 5;
    fetch(32'hC0, 0, 0, h);
    chk("t5_miss_after_rst", 32'(h), 32'd0);

    // back-to-back misses
    e0 = edges; p0 = pulses;
    fetch(32'h100, 0, 0, h);
    fetch(32'h200, 0, 0, h);
    chk("t6_rom_edges", 32'(edges - e0), 32'd2);
    chk("t6_ready_pulses", 32'(pulses - p0), 32'd2);

    // random traffic over a few sets and tags, including the top tag
    for (int it = 0; it < 60; it++) begin
      int tsel;
      int lat;
      int jat;
      tsel = $urandom_range(0, 2);
      a = (tsel == 2) ? 32'hFFFF_FC00 : 32'(tsel * 1024);
      a = a + 32'($urandom_range(8, 11) * 16) + 32'($urandom_range(0, LW-1) * 4);
      lat = $urandom_range(1, 6);
      rom_lat = lat;
      jat = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
      fetch(a, jat, 0, h);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        if_req = 1'b0;
        #1;
        chk("rand_idle_ready", 32'(rdy), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
